// File: rtl/memory_types_pkg.sv
// Shared memory-port types for the core, arbiter and memory model.
// Packet layout, transfer type and request source identifiers.
package memory_types_pkg;

   typedef enum logic [1:0] {
      MEM_RD = 2'd0,
      MEM_WR = 2'd1
   } mem_type_t;

   typedef struct packed {
      mem_type_t   typ;
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  strb;
   } mem_pkt_t;

   typedef enum logic {
      SRC_IMEM = 1'b0,
      SRC_DMEM = 1'b1
   } mem_src_t;

   typedef enum logic [1:0] {
      ARB_FREE   = 2'd0,
      ARB_LOCK_I = 2'd1,
      ARB_LOCK_D = 2'd2
   } arb_state_t;

   function automatic mem_src_t other_src(mem_src_t s);
      return (s == SRC_IMEM) ? SRC_DMEM : SRC_IMEM;
   endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Request/response memory port bundle.
// master issues requests and takes responses; slave does the reverse.
interface mem_arbiter_if;
   import memory_types_pkg::*;

   logic     req_vld;
   logic     req_rdy;
   mem_pkt_t req;
   logic     rsp_vld;
   logic     rsp_rdy;
   mem_pkt_t rsp;

   modport master (
      output req_vld,
      output req,
      output rsp_rdy,
      input  req_rdy,
      input  rsp_vld,
      input  rsp
   );

   modport slave (
      input  req_vld,
      input  req,
      input  rsp_rdy,
      output req_rdy,
      output rsp_vld,
      output rsp
   );

endinterface

// File: rtl/arb_src_fifo.sv
// Source-ID FIFO recording the order of issued memory requests.
// DEPTH must be a power of two so the pointers wrap naturally.
module arb_src_fifo
   import memory_types_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic     clk,
   input  logic     rst,
   input  logic     i_push,
   input  mem_src_t i_src,
   input  logic     i_pop,
   output logic     o_full,
   output logic     o_empty,
   output mem_src_t o_head
);

   localparam int AW = $clog2(DEPTH);

   mem_src_t      r_mem [DEPTH];
   logic [AW-1:0] r_wr;
   logic [AW-1:0] r_rd;
   logic [AW:0]   r_cnt;
   logic          w_push;
   logic          w_pop;

   assign o_full  = (r_cnt == (AW+1)'(DEPTH));
   assign o_empty = (r_cnt == '0);
   assign o_head  = r_mem[r_rd];
   assign w_push  = i_push && !o_full;
   assign w_pop   = i_pop && !o_empty;

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr] <= i_src;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr  <= '0;
         r_rd  <= '0;
         r_cnt <= '0;
      end else begin
         if (w_push) r_wr <= r_wr + AW'(1);
         if (w_pop)  r_rd <= r_rd + AW'(1);
         if (w_push && !w_pop)
            r_cnt <= r_cnt + (AW+1)'(1);
         else if (w_pop && !w_push)
            r_cnt <= r_cnt - (AW+1)'(1);
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin merge of imem/dmem onto one memory port with
// in-order response routing via a source-ID FIFO.
module mem_arbiter
   import memory_types_pkg::*;
#(
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic          clk,
   input  logic          rst,
   mem_arbiter_if.slave  imem,
   mem_arbiter_if.slave  dmem,
   mem_arbiter_if.master mem,
   output logic          spurious_rsp
);

   arb_state_t r_state;
   arb_state_t w_state_nxt;
   mem_src_t   r_rr_last;
   logic       r_spur;

   mem_src_t   w_gnt;
   mem_src_t   w_head;
   logic       w_gnt_vld;
   logic       w_req_vld;
   logic       w_req_rdy;
   logic       w_push;
   logic       w_pop;
   logic       w_full;
   logic       w_empty;
   logic       w_rsp_rdy;
   logic       w_irsp_vld;
   logic       w_drsp_vld;

   arb_src_fifo #(
      .DEPTH (MAX_OUTSTANDING)
   ) u_src_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_push),
      .i_src   (w_gnt),
      .i_pop   (w_pop),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_head  (w_head)
   );

   // A locked grant survives until its pending downstream transfer lands
   always_comb begin
      w_gnt = SRC_IMEM;
      unique case (r_state)
         ARB_LOCK_I: w_gnt = SRC_IMEM;
         ARB_LOCK_D: w_gnt = SRC_DMEM;
         default: begin
            if (imem.req_vld && dmem.req_vld)
               w_gnt = other_src(r_rr_last);
            else if (dmem.req_vld)
               w_gnt = SRC_DMEM;
         end
      endcase
   end

   assign w_gnt_vld = (w_gnt == SRC_DMEM) ? dmem.req_vld : imem.req_vld;
   assign w_req_vld = !rst && w_gnt_vld && !w_full;
   assign w_req_rdy = !rst && mem.req_rdy && !w_full;
   assign w_push    = w_req_vld && mem.req_rdy;

   assign mem.req_vld  = w_req_vld;
   assign mem.req      = (w_gnt == SRC_DMEM) ? dmem.req : imem.req;
   assign imem.req_rdy = w_req_rdy && (w_gnt == SRC_IMEM);
   assign dmem.req_rdy = w_req_rdy && (w_gnt == SRC_DMEM);

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         ARB_FREE: begin
            if (w_gnt_vld && !mem.req_rdy)
               w_state_nxt = (w_gnt == SRC_DMEM) ? ARB_LOCK_D : ARB_LOCK_I;
         end
         default: begin
            if (w_push) w_state_nxt = ARB_FREE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= ARB_FREE;
         r_rr_last <= SRC_IMEM;
         r_spur    <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (w_push) r_rr_last <= w_gnt;
         if (w_empty && mem.rsp_vld) r_spur <= 1'b1;
      end
   end

   // With nothing outstanding, responses are drained and flagged
   always_comb begin
      w_rsp_rdy  = 1'b1;
      w_irsp_vld = 1'b0;
      w_drsp_vld = 1'b0;
      if (!w_empty) begin
         unique case (w_head)
            SRC_IMEM: begin
               w_irsp_vld = mem.rsp_vld;
               w_rsp_rdy  = imem.rsp_rdy;
            end
            SRC_DMEM: begin
               w_drsp_vld = mem.rsp_vld;
               w_rsp_rdy  = dmem.rsp_rdy;
            end
         endcase
      end
   end

   assign w_pop = !w_empty && mem.rsp_vld && w_rsp_rdy;

   assign mem.rsp_rdy  = !rst && w_rsp_rdy;
   assign imem.rsp_vld = !rst && w_irsp_vld;
   assign dmem.rsp_vld = !rst && w_drsp_vld;
   assign imem.rsp     = mem.rsp;
   assign dmem.rsp     = mem.rsp;
   assign spurious_rsp = r_spur;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus
// randomized traffic against a queue-based reference model.
module tb_mem_arbiter;
   import memory_types_pkg::*;

   localparam int MAXO = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic spur;

   mem_arbiter_if imem_if ();
   mem_arbiter_if dmem_if ();
   mem_arbiter_if mem_if ();

   mem_arbiter #(
      .MAX_OUTSTANDING (MAXO)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .imem         (imem_if),
      .dmem         (dmem_if),
      .mem          (mem_if),
      .spurious_rsp (spur)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;

   // reference model state: outstanding source order, last grant, lock
   int          mq[$];
   mem_pkt_t    mem_pend[$];
   logic [31:0] exp_ia[$];
   logic [31:0] exp_da[$];
   int          m_last = 0;
   int          m_lock = -1;
   bit          m_spur = 1'b0;

   int       e_g;
   bit       e_gv, e_mvld, e_irdy, e_drdy, e_mrr, e_irv, e_drv;
   mem_pkt_t e_mreq;
   bit       i_acc, d_acc, r_acc;
   bit       rand_mode = 1'b0;

   task automatic check(input string tag, input logic [127:0] act,
                        input logic [127:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   function automatic mem_pkt_t mk(input logic [31:0] addr);
      mem_pkt_t p;
      p.typ  = MEM_RD;
      p.addr = addr;
      p.data = 32'h0;
      p.strb = 4'hF;
      return p;
   endfunction

   function automatic mem_pkt_t rand_pkt();
      mem_pkt_t p;
      p.typ  = ($urandom_range(0, 1) == 0) ? MEM_RD : MEM_WR;
      p.addr = $urandom & 32'hFFFF_FFFC;
      p.data = $urandom;
      p.strb = 4'($urandom_range(0, 15));
      return p;
   endfunction

   function automatic mem_pkt_t mk_rsp(input logic [31:0] data);
      mem_pkt_t p;
      p = (mem_pend.size() != 0) ? mem_pend[0] : mk(32'h0);
      p.data = data;
      return p;
   endfunction

   function automatic void model_reset();
      mq.delete();
      mem_pend.delete();
      exp_ia.delete();
      exp_da.delete();
      m_last = 0;
      m_lock = -1;
      m_spur = 1'b0;
   endfunction

   function automatic void model_comb();
      bit iv   = imem_if.req_vld;
      bit dv   = dmem_if.req_vld;
      bit full = (mq.size() == MAXO);
      if (m_lock >= 0)   e_g = m_lock;
      else if (iv && dv) e_g = 1 - m_last;
      else               e_g = dv ? 1 : 0;
      e_gv   = (e_g == 1) ? dv : iv;
      e_mvld = e_gv && !full;
      e_irdy = (e_g == 0) && mem_if.req_rdy && !full;
      e_drdy = (e_g == 1) && mem_if.req_rdy && !full;
      e_mreq = (e_g == 1) ? dmem_if.req : imem_if.req;
      if (mq.size() == 0) begin
         e_mrr = 1'b1;
         e_irv = 1'b0;
         e_drv = 1'b0;
      end else begin
         e_irv = (mq[0] == 0) && mem_if.rsp_vld;
         e_drv = (mq[0] == 1) && mem_if.rsp_vld;
         e_mrr = (mq[0] == 1) ? dmem_if.rsp_rdy : imem_if.rsp_rdy;
      end
   endfunction

   function automatic void model_seq();
      bit xfer = e_mvld && mem_if.req_rdy;
      bit pop  = (mq.size() != 0) && mem_if.rsp_vld && e_mrr;
      i_acc = xfer && (e_g == 0);
      d_acc = xfer && (e_g == 1);
      r_acc = mem_if.rsp_vld && e_mrr;
      if (mq.size() == 0 && mem_if.rsp_vld) m_spur = 1'b1;
      if (e_irv && imem_if.rsp_rdy && exp_ia.size() != 0)
         void'(exp_ia.pop_front());
      if (e_drv && dmem_if.rsp_rdy && exp_da.size() != 0)
         void'(exp_da.pop_front());
      if (pop) begin
         void'(mq.pop_front());
         if (mem_pend.size() != 0) void'(mem_pend.pop_front());
      end
      if (xfer) begin
         mq.push_back(e_g);
         mem_pend.push_back(e_mreq);
         if (e_g == 1) exp_da.push_back(e_mreq.addr);
         else          exp_ia.push_back(e_mreq.addr);
      end
      if (m_lock >= 0) begin
         if (xfer) m_lock = -1;
      end else if (e_gv && !mem_if.req_rdy) begin
         m_lock = e_g;
      end
      if (xfer) m_last = e_g;
   endfunction

   task automatic check_all();
      check("mem_req_vld", 128'(mem_if.req_vld), 128'(e_mvld));
      check("imem_req_rdy", 128'(imem_if.req_rdy), 128'(e_irdy));
      check("dmem_req_rdy", 128'(dmem_if.req_rdy), 128'(e_drdy));
      if (e_gv) check("mem_req", 128'(mem_if.req), 128'(e_mreq));
      check("imem_rsp_vld", 128'(imem_if.rsp_vld), 128'(e_irv));
      check("dmem_rsp_vld", 128'(dmem_if.rsp_vld), 128'(e_drv));
      check("mem_rsp_rdy", 128'(mem_if.rsp_rdy), 128'(e_mrr));
      check("spurious_rsp", 128'(spur), 128'(m_spur));
      if (e_irv) begin
         check("imem_rsp", 128'(imem_if.rsp), 128'(mem_if.rsp));
         if (exp_ia.size() != 0)
            check("imem_rsp_addr", 128'(imem_if.rsp.addr), 128'(exp_ia[0]));
      end
      if (e_drv) begin
         check("dmem_rsp", 128'(dmem_if.rsp), 128'(mem_if.rsp));
         if (exp_da.size() != 0)
            check("dmem_rsp_addr", 128'(dmem_if.rsp.addr), 128'(exp_da[0]));
      end
   endtask

   task automatic rst_checks();
      check("rst_imem_req_rdy", 128'(imem_if.req_rdy), 128'(1'b0));
      check("rst_dmem_req_rdy", 128'(dmem_if.req_rdy), 128'(1'b0));
      check("rst_imem_rsp_vld", 128'(imem_if.rsp_vld), 128'(1'b0));
      check("rst_dmem_rsp_vld", 128'(dmem_if.rsp_vld), 128'(1'b0));
      check("rst_mem_req_vld", 128'(mem_if.req_vld), 128'(1'b0));
      check("rst_mem_rsp_rdy", 128'(mem_if.rsp_rdy), 128'(1'b0));
      check("rst_spurious", 128'(spur), 128'(1'b0));
   endtask

   task automatic drive_random();
      if (i_acc || !imem_if.req_vld) begin
         imem_if.req_vld = ($urandom_range(0, 2) == 0);
         imem_if.req     = rand_pkt();
      end
      if (d_acc || !dmem_if.req_vld) begin
         dmem_if.req_vld = ($urandom_range(0, 2) == 0);
         dmem_if.req     = rand_pkt();
      end
      mem_if.req_rdy = ($urandom_range(0, 3) != 0);
      if (r_acc || !mem_if.rsp_vld) begin
         if (mem_pend.size() != 0 && $urandom_range(0, 1) == 1) begin
            mem_if.rsp_vld = 1'b1;
            mem_if.rsp     = mk_rsp($urandom);
         end else begin
            mem_if.rsp_vld = 1'b0;
         end
      end
      imem_if.rsp_rdy = ($urandom_range(0, 3) != 0);
      dmem_if.rsp_rdy = ($urandom_range(0, 3) != 0);
   endtask

   task automatic neg();
      @(negedge clk);
      model_comb();
      check_all();
   endtask

   task automatic pos();
      @(posedge clk);
      model_seq();
      #1;
      if (rand_mode) drive_random();
   endtask

   task automatic idle_inputs();
      imem_if.req_vld = 1'b0;
      dmem_if.req_vld = 1'b0;
      imem_if.req     = mk(32'h0);
      dmem_if.req     = mk(32'h0);
      imem_if.rsp_rdy = 1'b1;
      dmem_if.rsp_rdy = 1'b1;
      mem_if.req_rdy  = 1'b0;
      mem_if.rsp_vld  = 1'b0;
      mem_if.rsp      = mk(32'h0);
   endtask

   task automatic drain();
      imem_if.req_vld = 1'b0;
      dmem_if.req_vld = 1'b0;
      mem_if.req_rdy  = 1'b0;
      imem_if.rsp_rdy = 1'b1;
      dmem_if.rsp_rdy = 1'b1;
      for (int k = 0; k < 4 * MAXO && mem_pend.size() != 0; k++) begin
         mem_if.rsp_vld = 1'b1;
         mem_if.rsp     = mk_rsp(32'hC0DE_0000 + 32'(k));
         neg();
         pos();
      end
      mem_if.rsp_vld = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] tie_exp [4];
      logic [1:0]  ord_exp [4];
      tie_exp = '{32'h2000, 32'h1000, 32'h2000, 32'h1000};
      ord_exp = '{2'b10, 2'b01, 2'b10, 2'b01};

      idle_inputs();
      #2;
      rst_checks();
      @(posedge clk);
      @(posedge clk);
      #1;
      model_reset();
      rst = 1'b0;

      // tie alternation from reset, then fill to MAX_OUTSTANDING
      imem_if.req     = mk(32'h1000);
      dmem_if.req     = mk(32'h2000);
      imem_if.req_vld = 1'b1;
      dmem_if.req_vld = 1'b1;
      mem_if.req_rdy  = 1'b1;
      for (int k = 0; k < 4; k++) begin
         neg();
         check("tie_grant", 128'(mem_if.req.addr), 128'(tie_exp[k]));
         pos();
      end
      neg();
      check("full_imem_rdy", 128'(imem_if.req_rdy), 128'(1'b0));
      check("full_dmem_rdy", 128'(dmem_if.req_rdy), 128'(1'b0));
      pos();
      mem_if.rsp_vld = 1'b1;
      mem_if.rsp     = mk_rsp(32'h1111);
      neg();
      check("full_pop_same_cycle", 128'(dmem_if.req_rdy), 128'(1'b0));
      check("first_push_src_dmem", 128'(dmem_if.rsp_vld), 128'(1'b1));
      pos();
      mem_if.rsp_vld = 1'b0;
      neg();
      check("push_after_pop", 128'(dmem_if.req_rdy), 128'(1'b1));
      pos();
      imem_if.req_vld = 1'b0;
      dmem_if.req_vld = 1'b0;
      mem_if.req_rdy  = 1'b0;
      for (int k = 0; k < 4; k++) begin
         mem_if.rsp_vld = 1'b1;
         mem_if.rsp     = mk_rsp(32'h2220 + 32'(k));
         neg();
         check("rsp_order", 128'({imem_if.rsp_vld, dmem_if.rsp_vld}),
               128'(ord_exp[k]));
         pos();
      end
      mem_if.rsp_vld = 1'b0;

      // lock: imem held through back-pressure while dmem waits
      imem_if.req     = mk(32'h104);
      imem_if.req_vld = 1'b1;
      mem_if.req_rdy  = 1'b1;
      neg();
      pos();
      imem_if.req    = mk(32'h108);
      mem_if.req_rdy = 1'b0;
      for (int k = 0; k < 3; k++) begin
         neg();
         check("lock_hold", 128'(mem_if.req.addr), 128'(32'h108));
         check("lock_dmem_rdy", 128'(dmem_if.req_rdy), 128'(1'b0));
         pos();
         dmem_if.req     = mk(32'h2004);
         dmem_if.req_vld = 1'b1;
      end
      mem_if.req_rdy = 1'b1;
      neg();
      check("lock_release_imem", 128'(imem_if.req_rdy), 128'(1'b1));
      pos();
      imem_if.req = mk(32'h10C);
      neg();
      check("after_lock_dmem", 128'(dmem_if.req_rdy), 128'(1'b1));
      check("after_lock_addr", 128'(mem_if.req.addr), 128'(32'h2004));
      pos();
      drain();

      // routing and response back-pressure
      imem_if.req     = mk(32'h100);
      imem_if.req_vld = 1'b1;
      mem_if.req_rdy  = 1'b1;
      neg();
      pos();
      imem_if.req_vld = 1'b0;
      dmem_if.req     = mk(32'h2000);
      dmem_if.req_vld = 1'b1;
      neg();
      pos();
      dmem_if.req_vld = 1'b0;
      mem_if.req_rdy  = 1'b0;
      dmem_if.rsp_rdy = 1'b0;
      mem_if.rsp_vld  = 1'b1;
      mem_if.rsp      = mk_rsp(32'hDEAD);
      neg();
      check("route_imem_vld", 128'(imem_if.rsp_vld), 128'(1'b1));
      check("route_imem_data", 128'(imem_if.rsp.data), 128'(32'hDEAD));
      pos();
      mem_if.rsp = mk_rsp(32'hBEEF);
      for (int k = 0; k < 2; k++) begin
         neg();
         check("bp_dmem_vld", 128'(dmem_if.rsp_vld), 128'(1'b1));
         check("bp_mem_rsp_rdy", 128'(mem_if.rsp_rdy), 128'(1'b0));
         pos();
      end
      dmem_if.rsp_rdy = 1'b1;
      neg();
      check("route_dmem_data", 128'(dmem_if.rsp.data), 128'(32'hBEEF));
      check("route_mem_rsp_rdy", 128'(mem_if.rsp_rdy), 128'(1'b1));
      pos();
      mem_if.rsp_vld = 1'b0;

      // randomized traffic
      rand_mode = 1'b1;
      drive_random();
      for (int k = 0; k < 600; k++) begin
         neg();
         pos();
      end
      rand_mode = 1'b0;

      // reset mid-run
      imem_if.req     = mk(32'h1000);
      dmem_if.req     = mk(32'h2000);
      imem_if.req_vld = 1'b1;
      dmem_if.req_vld = 1'b1;
      mem_if.req_rdy  = 1'b1;
      mem_if.rsp_vld  = 1'b1;
      imem_if.rsp_rdy = 1'b1;
      dmem_if.rsp_rdy = 1'b1;
      rst = 1'b1;
      #1;
      rst_checks();
      model_reset();
      @(posedge clk);
      @(posedge clk);
      #1;
      mem_if.rsp_vld = 1'b0;
      rst = 1'b0;
      neg();
      check("rst_first_tie", 128'(mem_if.req.addr), 128'(32'h2000));
      pos();
      drain();

      // spurious response with nothing outstanding
      mem_if.rsp_vld = 1'b1;
      mem_if.rsp     = rand_pkt();
      neg();
      check("spur_drain_rdy", 128'(mem_if.rsp_rdy), 128'(1'b1));
      check("spur_no_core_vld",
            128'({imem_if.rsp_vld, dmem_if.rsp_vld}), 128'(2'b00));
      pos();
      mem_if.rsp_vld = 1'b0;
      for (int k = 0; k < 3; k++) begin
         neg();
         check("spur_sticky", 128'(spur), 128'(1'b1));
         pos();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
